// File: rtl/lc3_writeback_pkg.sv
// ============================================================================
// Module   : lc3_writeback_pkg
// Purpose  : Shared types and constants for the LC-3 writeback stage.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package lc3_writeback_pkg;

  typedef enum logic [1:0] {
    WB_ALU  = 2'd0,
    WB_MEM  = 2'd1,
    WB_PC   = 2'd2,
    WB_RSVD = 2'd3
  } wb_sel_t;

  typedef logic [15:0] lc3_word_t;
  typedef logic [2:0]  reg_idx_t;

  localparam int PSR_N = 2;
  localparam int PSR_Z = 1;
  localparam int PSR_P = 0;

  // Exactly one of N/Z/P is set for any committed value.
  function automatic logic [2:0] cc_of(input lc3_word_t value);
    logic [2:0] cc;
    cc        = 3'b000;
    cc[PSR_N] = value[15];
    cc[PSR_Z] = (value == 16'h0000);
    cc[PSR_P] = !value[15] && (value != 16'h0000);
    return cc;
  endfunction

endpackage : lc3_writeback_pkg

`default_nettype wire

// File: rtl/lc3_regfile.sv
// ============================================================================
// Module   : lc3_regfile
// Purpose  : 1W/2R register file, async clear; LC3_WRITEBACK_BYPASS_EN adds
//            same-cycle write-to-read forwarding.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module lc3_regfile
  import lc3_writeback_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int REG_ADDR_W = 3,
  parameter int NUM_REGS   = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  i_we,
  input  logic [REG_ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0]     i_wdata,
  input  logic [REG_ADDR_W-1:0] i_raddr1,
  input  logic [REG_ADDR_W-1:0] i_raddr2,
  output logic [DATA_W-1:0]     o_rdata1,
  output logic [DATA_W-1:0]     o_rdata2
);

  logic [DATA_W-1:0] r_regs [NUM_REGS];
  logic [DATA_W-1:0] w_rf1;
  logic [DATA_W-1:0] w_rf2;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= '0;
      end
    end else if (i_we) begin
      r_regs[i_waddr] <= i_wdata;
    end
  end

  assign w_rf1 = r_regs[i_raddr1];
  assign w_rf2 = r_regs[i_raddr2];

`ifdef LC3_WRITEBACK_BYPASS_EN
  // Forward the value being committed this cycle ahead of the array update.
  assign o_rdata1 = (i_we && (i_waddr == i_raddr1)) ? i_wdata : w_rf1;
  assign o_rdata2 = (i_we && (i_waddr == i_raddr2)) ? i_wdata : w_rf2;
`else
  assign o_rdata1 = w_rf1;
  assign o_rdata2 = w_rf2;
`endif

endmodule : lc3_regfile

`default_nettype wire

// File: rtl/lc3_writeback.sv
// ============================================================================
// Module   : lc3_writeback
// Purpose  : LC-3 writeback stage: value select, register file commit, N/Z/P
//            codes. Optional macro: LC3_WRITEBACK_BYPASS_EN (read forwarding).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module lc3_writeback
  import lc3_writeback_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int REG_ADDR_W = 3,
  parameter int NUM_REGS   = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [DATA_W-1:0]     npc,
  input  logic [1:0]            W_Control,
  input  logic [DATA_W-1:0]     aluout,
  input  logic [DATA_W-1:0]     pcout,
  input  logic [DATA_W-1:0]     memout,
  input  logic                  enable_writeback,
  input  logic [REG_ADDR_W-1:0] sr1,
  input  logic [REG_ADDR_W-1:0] sr2,
  input  logic [REG_ADDR_W-1:0] dr,
  output logic [DATA_W-1:0]     d1,
  output logic [DATA_W-1:0]     d2,
  output logic [2:0]            psr,
  output logic [DATA_W-1:0]     wb_npc,
  output logic                  wb_valid
);

  wb_sel_t           w_sel;
  logic              w_commit;
  logic [DATA_W-1:0] w_wdata;
  logic [2:0]        w_cc;
  logic [2:0]        r_psr;
  logic [DATA_W-1:0] r_wb_npc;
  logic              r_wb_valid;

  assign w_sel    = wb_sel_t'(W_Control);
  assign w_commit = enable_writeback && (w_sel != WB_RSVD);

  always_comb begin
    w_wdata = '0;
    unique case (w_sel)
      WB_ALU:  w_wdata = aluout;
      WB_MEM:  w_wdata = memout;
      WB_PC:   w_wdata = pcout;
      default: w_wdata = '0;
    endcase
  end

  always_comb begin
    w_cc        = 3'b000;
    w_cc[PSR_N] = w_wdata[DATA_W-1];
    w_cc[PSR_Z] = (w_wdata == '0);
    w_cc[PSR_P] = !w_wdata[DATA_W-1] && (w_wdata != '0);
  end

  lc3_regfile #(
    .DATA_W     (DATA_W),
    .REG_ADDR_W (REG_ADDR_W),
    .NUM_REGS   (NUM_REGS)
  ) u_regfile (
    .clock    (clock),
    .reset    (reset),
    .i_we     (w_commit),
    .i_waddr  (dr),
    .i_wdata  (w_wdata),
    .i_raddr1 (sr1),
    .i_raddr2 (sr2),
    .o_rdata1 (d1),
    .o_rdata2 (d2)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_psr      <= 3'b000;
      r_wb_npc   <= '0;
      r_wb_valid <= 1'b0;
    end else begin
      r_wb_valid <= w_commit;
      if (w_commit) begin
        r_psr    <= w_cc;
        r_wb_npc <= npc;
      end
    end
  end

  assign psr      = r_psr;
  assign wb_npc   = r_wb_npc;
  assign wb_valid = r_wb_valid;

`ifndef SYNTHESIS
  // The reserved select is legal on the bus but signals an upstream bug.
  always @(posedge clock) begin
    if (!reset) begin
      assert (!(enable_writeback && (w_sel == WB_RSVD)))
        else $warning("lc3_writeback: reserved W_Control with enable_writeback, write dropped");
    end
  end
`endif

endmodule : lc3_writeback

`default_nettype wire

// File: tb/tb_lc3_writeback.sv
// ============================================================================
// Module   : tb_lc3_writeback
// Purpose  : Self-checking bench for lc3_writeback against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_lc3_writeback;

  logic        clock = 1'b0;
  logic        reset;
  logic [15:0] npc;
  logic [1:0]  W_Control;
  logic [15:0] aluout;
  logic [15:0] pcout;
  logic [15:0] memout;
  logic        enable_writeback;
  logic [2:0]  sr1;
  logic [2:0]  sr2;
  logic [2:0]  dr;
  logic [15:0] d1;
  logic [15:0] d2;
  logic [2:0]  psr;
  logic [15:0] wb_npc;
  logic        wb_valid;

  int checks = 0;
  int errors = 0;

  // Reference state
  logic [15:0] m_rf [8];
  logic [2:0]  m_psr;
  logic [15:0] m_npc;
  logic        m_valid;

  lc3_writeback dut (
    .clock            (clock),
    .reset            (reset),
    .npc              (npc),
    .W_Control        (W_Control),
    .aluout           (aluout),
    .pcout            (pcout),
    .memout           (memout),
    .enable_writeback (enable_writeback),
    .sr1              (sr1),
    .sr2              (sr2),
    .dr               (dr),
    .d1               (d1),
    .d2               (d2),
    .psr              (psr),
    .wb_npc           (wb_npc),
    .wb_valid         (wb_valid)
  );

  always #5 clock = ~clock;

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
  endtask

  function automatic logic commit_now();
    return enable_writeback && (W_Control != 2'd3);
  endfunction

  function automatic logic [15:0] sel_value();
    if (W_Control == 2'd0) return aluout;
    if (W_Control == 2'd1) return memout;
    return pcout;
  endfunction

  function automatic logic [2:0] cc_model(input logic [15:0] v);
    if ($signed(v) < 0)  return 3'b100;
    if (v == 16'h0000)   return 3'b010;
    return 3'b001;
  endfunction

  function automatic logic [15:0] exp_read(input logic [2:0] idx);
`ifdef LC3_WRITEBACK_BYPASS_EN
    if (commit_now() && dr == idx) return sel_value();
`endif
    return m_rf[idx];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_rf[i] = 16'h0000;
    m_psr   = 3'b000;
    m_npc   = 16'h0000;
    m_valid = 1'b0;
  endtask

  task automatic check_all(input string tag);
    check({tag, ".d1"},       d1, exp_read(sr1));
    check({tag, ".d2"},       d2, exp_read(sr2));
    check({tag, ".psr"},      {13'd0, psr}, {13'd0, m_psr});
    check({tag, ".wb_npc"},   wb_npc, m_npc);
    check({tag, ".wb_valid"}, {15'd0, wb_valid}, {15'd0, m_valid});
  endtask

  // Called at a negedge: apply inputs, check pre-edge reads, clock, check state.
  task automatic step(input string tag, input logic en, input logic [1:0] wc,
                      input logic [15:0] alu, input logic [15:0] mem,
                      input logic [15:0] pc, input logic [15:0] npcv,
                      input logic [2:0] d, input logic [2:0] s1, input logic [2:0] s2);
    enable_writeback = en;
    W_Control        = wc;
    aluout           = alu;
    memout           = mem;
    pcout            = pc;
    npc              = npcv;
    dr               = d;
    sr1              = s1;
    sr2              = s2;
    #1;
    check({tag, ".pre.d1"}, d1, exp_read(sr1));
    check({tag, ".pre.d2"}, d2, exp_read(sr2));
    @(posedge clock);
    if (commit_now()) begin
      m_rf[dr] = sel_value();
      m_psr    = cc_model(sel_value());
      m_npc    = npc;
    end
    m_valid = commit_now();
    #1;
    check_all({tag, ".post"});
    @(negedge clock);
  endtask

  initial begin
    reset            = 1'b1;
    npc              = '0;
    W_Control        = '0;
    aluout           = '0;
    pcout            = '0;
    memout           = '0;
    enable_writeback = 1'b0;
    sr1              = '0;
    sr2              = '0;
    dr               = '0;
    model_reset();

    repeat (2) @(posedge clock);
    #1;
    check_all("reset");
    @(negedge clock);
    reset = 1'b0;

    for (int a = 0; a < 8; a++) begin
      for (int b = 0; b < 8; b++) begin
        sr1 = a[2:0];
        sr2 = b[2:0];
        #0.1;
        check("rst_read.d1", d1, 16'h0000);
        check("rst_read.d2", d2, 16'h0000);
      end
    end

    step("alu_neg",  1'b1, 2'd0, 16'h8001, 16'h0,    16'h0,    16'h3001, 3'd3, 3'd3, 3'd0);
    check("alu_neg.d1",  d1, 16'h8001);
    check("alu_neg.psr", {13'd0, psr}, 16'h0004);
    check("alu_neg.npc", wb_npc, 16'h3001);
    step("idle",     1'b0, 2'd0, 16'h0,    16'h0,    16'h0,    16'h0,    3'd0, 3'd3, 3'd3);
    check("pulse_end", {15'd0, wb_valid}, 16'h0000);
    step("mem_zero", 1'b1, 2'd1, 16'h7777, 16'h0000, 16'h1111, 16'h3002, 3'd5, 3'd5, 3'd3);
    check("mem_zero.psr", {13'd0, psr}, 16'h0002);
    step("pc_pos",   1'b1, 2'd2, 16'h7777, 16'h2222, 16'h0042, 16'h3003, 3'd5, 3'd5, 3'd5);
    check("pc_pos.d1",  d1, 16'h0042);
    check("pc_pos.psr", {13'd0, psr}, 16'h0001);
    step("rsvd",     1'b1, 2'd3, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'h4000, 3'd2, 3'd2, 3'd5);
    check("rsvd.d1", d1, 16'h0000);
    step("disabled", 1'b0, 2'd0, 16'hFFFF, 16'h0,    16'h0,    16'h4001, 3'd2, 3'd2, 3'd2);
    step("r4_seed",  1'b1, 2'd0, 16'h00AA, 16'h0,    16'h0,    16'h3004, 3'd4, 3'd0, 3'd1);
    step("collide",  1'b1, 2'd0, 16'h1234, 16'h0,    16'h0,    16'h3005, 3'd4, 3'd4, 3'd4);
    check("collide.next", d1, 16'h1234);

    // Asynchronous reset between edges must clear state before the next edge.
    step("r7_write", 1'b1, 2'd0, 16'h5555, 16'h0,    16'h0,    16'h3006, 3'd7, 3'd7, 3'd7);
    enable_writeback = 1'b1;
    W_Control        = 2'd0;
    aluout           = 16'hFFFF;
    dr               = 3'd7;
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    check("async_rst.d1",  d1, 16'h0000);
    check("async_rst.psr", {13'd0, psr}, 16'h0000);
    check("async_rst.vld", {15'd0, wb_valid}, 16'h0000);
    @(posedge clock);
    #1;
    check("rst_hold.d1",  d1, 16'h0000);
    check("rst_hold.npc", wb_npc, 16'h0000);
    @(negedge clock);
    reset            = 1'b0;
    enable_writeback = 1'b0;

    for (int n = 0; n < 300; n++) begin
      logic [1:0] wc;
      wc = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      step("rand", 1'($urandom_range(0, 3) != 0), wc,
           16'($urandom), ($urandom_range(0, 5) == 0) ? 16'h0000 : 16'($urandom),
           16'($urandom), 16'($urandom),
           3'($urandom), 3'($urandom), 3'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_lc3_writeback

`default_nettype wire
